// File: rtl/usb_uart_line_buffer.sv
// usb_uart_line_buffer
// Assembles host bytes into lines with backspace editing and only releases
// bytes downstream once their line is committed (EOL byte or buffer full).
// Three wrapping pointers: wr (next write), cm (commit point), rd (next fetch),
// with rd <= cm <= wr in wrapped distance.

module usb_uart_line_buffer #(
  parameter int          DEPTH_LOG2 = 6,
  parameter logic [7:0]  EOL        = 8'h0D,
  parameter logic [7:0]  BS         = 8'h08
) (
  input  logic                  clk_48mhz,
  input  logic                  reset_n,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  line_done
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE    = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_VALID = 1'b1;

  logic [DEPTH_LOG2:0] wr;
  logic [DEPTH_LOG2:0] cm;
  logic [DEPTH_LOG2:0] rd;
  logic [0:0]          state;
  logic [7:0]          mem [DEPTH];

  logic accept;
  logic is_bs;
  logic is_eol;
  logic write_en;
  logic handshake;
  logic force_commit;
  logic fetch;

  // The held output byte still counts toward level until it is handed off,
  // so level is the RAM occupancy plus the output register.
  assign out_valid = (state == ST_VALID);
  assign level     = wr - rd + {{DEPTH_LOG2{1'b0}}, out_valid};
  assign in_ready  = (level != FULL_LEVEL);

  assign accept    = in_valid & in_ready;
  assign is_bs     = (in_data == BS);
  assign is_eol    = (in_data == EOL);
  assign write_en  = accept & ~is_bs;
  assign handshake = out_valid & out_ready;

  // A plain byte that leaves the buffer completely full must commit the line,
  // otherwise nothing could ever drain and input would stall forever.
  assign force_commit = write_en & ~is_eol & ~handshake &
                        (level == FULL_LEVEL - PTR_ONE);

  // Fetch a committed byte whenever the output register is free or being
  // emptied this cycle; uses the cm value from before this edge.
  assign fetch = (~out_valid | out_ready) & (rd != cm);

  // Byte storage, no reset needed since pointers guard every read.
  always_ff @(posedge clk_48mhz) begin
    if (write_en) begin
      mem[wr[DEPTH_LOG2-1:0]] <= in_data;
    end
  end

  // Write side: appends bytes, handles backspace and line commits.
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      wr        <= '0;
      cm        <= '0;
      line_done <= 1'b0;
    end else begin
      line_done <= 1'b0;
      if (accept) begin
        if (is_bs) begin
          if (wr != cm) begin
            wr <= wr - PTR_ONE;
          end
        end else begin
          wr <= wr + PTR_ONE;
          if (is_eol || force_commit) begin
            cm        <= wr + PTR_ONE;
            line_done <= 1'b1;
          end
        end
      end
    end
  end

  // Read side: two-state output register that holds its byte until accepted.
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      rd       <= '0;
      state    <= ST_EMPTY;
      out_data <= 8'h00;
    end else begin
      if (fetch) begin
        out_data <= mem[rd[DEPTH_LOG2-1:0]];
        rd       <= rd + PTR_ONE;
        state    <= ST_VALID;
      end else if (handshake) begin
        state <= ST_EMPTY;
      end
    end
  end

endmodule

// File: doc/usb_uart_line_buffer.md
# usb_uart_line_buffer

Line-assembling byte buffer that sits directly downstream of the `usb_uart` receive stream (`uart_out_*`) and upstream of whatever consumes host input: the loopback path back into `uart_in_*`, or a command parser. It accepts bytes from the host, supports backspace editing of the uncommitted line, and releases bytes downstream only once a whole line is committed. A line is committed by an end-of-line byte or by the buffer filling up. Streams use the same valid/ready handshake as `usb_uart`.

## Interface
- `DEPTH_LOG2`, 6: buffer depth is 2^DEPTH_LOG2 bytes (64).
- `EOL`, 8'h0D: byte that commits a line. It is stored and forwarded.
- `BS`, 8'h08: backspace byte. It is never stored.

- `clk_48mhz`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  byte from `usb_uart.uart_out_data`.
- `in_valid`  in  1  input byte valid.
- `in_ready`  out  1  buffer can accept a byte.
- `out_data`  out  8  committed byte to the downstream consumer.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts the byte.
- `level`  out  DEPTH_LOG2+1  bytes stored, committed plus uncommitted.
- `line_done`  out  1  one-cycle pulse when a line is committed.

## Operation
- **Pointers.** Three pointers, each DEPTH_LOG2+1 bits and wrapping modulo 2^(DEPTH_LOG2+1): `wr`, `cm` (commit) and `rd`.
  - RAM address is the low DEPTH_LOG2 bits.
  - Pointer order is always rd ≤ cm ≤ wr, measured in wrapped distance.
- **Derived signals.**
  - `level` = wr − rd.
  - full ⇔ level == 2^DEPTH_LOG2.
  - `in_ready` = !full.
- **Accept.** An input byte is accepted when `in_valid & in_ready` at a rising edge.
  - **BS byte:** if wr ≠ cm, then wr ← wr − 1 and the last uncommitted byte is discarded. If wr == cm, the byte is discarded and no state changes. BS never crosses the commit point.
  - **EOL byte:** RAM[wr] ← byte; wr ← wr+1; cm ← wr+1; `line_done` pulses.
  - **Any other byte:** RAM[wr] ← byte; wr ← wr+1. If this write makes the buffer full, cm ← wr+1 (forced commit, so the design cannot deadlock) and `line_done` pulses.
- **Output stage.** Two-state machine with registered output.
  - **EMPTY** (`out_valid`=0): if rd ≠ cm, fetch RAM[rd], rd ← rd+1, then go to VALID.
  - **VALID** (`out_valid`=1): `out_data` is held stable until `out_ready`. On `out_valid & out_ready`:
    - if rd ≠ cm, load the next byte, rd ← rd+1, and stay in VALID;
    - otherwise go to EMPTY.
- **Rules.**
  - Uncommitted bytes are never presented downstream.
  - `level` counts the byte held in the output register until it is handed off. Implementation: decrement on handshake, not on fetch.
- **Simultaneous events.** Write/commit and read/handshake may occur in the same cycle. The read side uses the cm value registered before the edge, so a byte committed at edge N is first fetchable in the cycle after edge N. A BS in the same cycle as a read is legal because BS only touches wr.
- **Reset.** Asserting `reset_n`=0 at any time, including mid-line or mid-handshake, asynchronously forces:
  - wr=cm=rd=0, state EMPTY;
  - `out_valid`=0, `out_data`=0, `line_done`=0;
  - `level`=0, `in_ready`=1.
  
  Buffer contents are discarded. RAM contents need no reset.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=8'h00, `level`=0, `line_done`=0.
- Latency: EOL accepted at edge N gives `line_done`=1 during cycle N..N+1 and `out_valid`=1 from edge N+1, with the first byte of the line on `out_data`.
- Throughput: with `out_ready` held high, one byte per clock is sustained until rd == cm. Input accepts one byte per clock while not full.
- `in_ready` is registered-equivalent. It depends only on pointers, never combinationally on `in_valid` or `out_ready`.
- `out_valid`, once high, does not drop and `out_data` does not change until the handshake completes.
- `level` updates at the edge following the write or handshake it reflects.

## Test plan
- **Reset and idle:** assert `reset_n`=0 mid-stream, release → `in_ready`=1, `out_valid`=0, `level`=0. No stale bytes appear afterwards.
- **Simple line:** send 'A','B',0x0D with `out_ready`=1 → nothing is output before the 0x0D edge. Then 41,42,0D appear on consecutive cycles starting at edge N+1, and `line_done` pulses once.
- **Backspace editing:** send 'A','B',BS,'C',0x0D → output 41,43,0D. A BS sent immediately after the commit changes nothing, and `level` is unaffected.
- **Forced commit:** with `out_ready`=0, send 64 bytes of 0x55 and no EOL → `in_ready`=0 after the 64th byte, `level`=64, `line_done` pulses, and `out_valid`=1. Raise `out_ready` → exactly 64 bytes drain and `in_ready` returns to 1.
- **Wrap-around and concurrency:** stream 200 random lines of random length (each ≤ 63, each ending in 0x0D) with random `in_valid`/`out_ready` → the output equals the reference-model sequence and `level` never exceeds 64.
- **Backpressure hold:** toggle `out_ready` randomly → `out_data` is stable while `out_valid` & !`out_ready`, with no byte dropped or duplicated.
